// File: rtl/branch_decoder_unit_pkg.sv
// Shared next-PC source encoding produced by the branch decoder in execute.
// Purely type definitions; no timing or flow control.
package branch_decoder_unit_pkg;

    typedef enum logic [1:0] {
        PcPlus4             = 2'd0,
        PcOrReadDataPlusImm = 2'd1,
        Mepc                = 2'd2,
        Sepc                = 2'd3
    } pc_src_t;

endpackage

// File: rtl/fetch_unit_pkg.sv
// Fetch-side state encoding and the instruction presented to decode when nothing is valid.
// Purely type definitions; no timing or flow control.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        Idle    = 2'd0,
        Fetch   = 2'd1,
        Deliver = 2'd2
    } fetch_state_t;

    localparam logic [31:0] Nop = 32'h0000_0013;

endpackage

// File: rtl/next_pc_selector.sv
// Picks the redirect target (trap > pc_src redirect) and computes the sequential pc+4.
// Combinational, zero latency; no backpressure.
module next_pc_selector
    import branch_decoder_unit_pkg::*;
#(
    parameter int Width = 64
) (
    input  logic             trap,
    input  logic [Width-1:0] trap_addr,
    input  logic             redirect_valid,
    input  pc_src_t          pc_src,
    input  logic [Width-1:0] branch_target,
    input  logic [Width-1:0] mepc,
    input  logic [Width-1:0] sepc,
    input  logic [Width-1:0] pc,
    output logic [Width-1:0] target,
    output logic             redirect,
    output logic [Width-1:0] pc_plus_4
);

    logic [Width-1:0] raw_target;

    always_comb begin
        raw_target = branch_target;
        case (pc_src)
            Mepc:    raw_target = mepc;
            Sepc:    raw_target = sepc;
            default: raw_target = branch_target;
        endcase
        if (trap) begin
            raw_target = trap_addr;
        end
    end

    // Instructions are word aligned, so the low two bits of any loaded target are dropped.
    assign target    = {raw_target[Width-1:2], 2'b00};
    assign redirect  = trap || (redirect_valid && (pc_src != PcPlus4));
    assign pc_plus_4 = pc + Width'(4);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Owns the PC, runs the imem req/ack handshake and delivers one instruction per fetch to decode.
// Latency: inst_valid the cycle after imem_ack; one instruction per two cycles at zero wait.
// Backpressure: stall holds the delivered instruction; imem_req is held until imem_ack.
module instruction_fetch_unit
    import branch_decoder_unit_pkg::*;
    import fetch_unit_pkg::*;
#(
    parameter int               Width     = 64,
    parameter logic [Width-1:0] ResetAddr = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  pc_src_t          pc_src,
    input  logic             redirect_valid,
    input  logic [Width-1:0] branch_target,
    input  logic [Width-1:0] mepc,
    input  logic [Width-1:0] sepc,
    input  logic             trap,
    input  logic [Width-1:0] trap_addr,
    input  logic             stall,
    output logic             imem_req,
    output logic [Width-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rd_data,
    output logic [Width-1:0] pc,
    output logic [31:0]      inst,
    output logic             inst_valid
);

    fetch_state_t     state, state_nxt;
    logic [Width-1:0] pc_q, pc_nxt;
    logic [Width-1:0] redirect_pc, redirect_pc_nxt;
    logic             kill, kill_nxt;
    logic [31:0]      inst_q, inst_nxt;

    logic [Width-1:0] target;
    logic             redirect;
    logic [Width-1:0] pc_plus_4;

    next_pc_selector #(.Width(Width)) u_next_pc_selector (
        .trap           (trap),
        .trap_addr      (trap_addr),
        .redirect_valid (redirect_valid),
        .pc_src         (pc_src),
        .branch_target  (branch_target),
        .mepc           (mepc),
        .sepc           (sepc),
        .pc             (pc_q),
        .target         (target),
        .redirect       (redirect),
        .pc_plus_4      (pc_plus_4)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= Idle;
            pc_q        <= ResetAddr;
            redirect_pc <= '0;
            kill        <= 1'b0;
            inst_q      <= Nop;
        end else begin
            state       <= state_nxt;
            pc_q        <= pc_nxt;
            redirect_pc <= redirect_pc_nxt;
            kill        <= kill_nxt;
            inst_q      <= inst_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc_q;
        redirect_pc_nxt = redirect_pc;
        kill_nxt        = kill;
        inst_nxt        = inst_q;
        imem_req        = 1'b0;
        inst_valid      = 1'b0;
        case (state)
            Idle: begin
                state_nxt = Fetch;
            end
            Fetch: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (kill || redirect) begin
                        // Stale data: retarget and refetch; a same-cycle redirect beats the saved one.
                        pc_nxt   = redirect ? target : redirect_pc;
                        kill_nxt = 1'b0;
                    end else begin
                        inst_nxt  = imem_rd_data;
                        state_nxt = Deliver;
                    end
                end else if (redirect) begin
                    // Address must stay stable until ack, so remember the target instead.
                    kill_nxt        = 1'b1;
                    redirect_pc_nxt = target;
                end
            end
            Deliver: begin
                inst_valid = 1'b1;
                if (redirect) begin
                    pc_nxt    = target;
                    state_nxt = Fetch;
                end else if (!stall) begin
                    pc_nxt    = pc_plus_4;
                    state_nxt = Fetch;
                end
            end
            default: begin
                state_nxt = Idle;
            end
        endcase
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign inst      = inst_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: table of sequential fetches plus redirect/stall/reset sequences.
module tb_instruction_fetch_unit;
    import branch_decoder_unit_pkg::*;

    localparam int          W     = 64;
    localparam logic [63:0] RADDR = 64'h1000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    pc_src_t     pc_src = PcPlus4;
    logic        redirect_valid = 1'b0;
    logic [63:0] branch_target = '0;
    logic [63:0] mepc = '0;
    logic [63:0] sepc = '0;
    logic        trap = 1'b0;
    logic [63:0] trap_addr = '0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rd_data = '0;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        inst_valid;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } sb_item_t;
    sb_item_t sb[$];

    typedef struct {
        int unsigned wait_cycles;
        logic [31:0] data;
        logic [63:0] exp_addr;
    } vec_t;
    vec_t vecs[4];

    always #5 clock = ~clock;

    instruction_fetch_unit #(.Width(W), .ResetAddr(RADDR)) dut (
        .clock          (clock),
        .reset          (reset),
        .pc_src         (pc_src),
        .redirect_valid (redirect_valid),
        .branch_target  (branch_target),
        .mepc           (mepc),
        .sepc           (sepc),
        .trap           (trap),
        .trap_addr      (trap_addr),
        .stall          (stall),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rd_data   (imem_rd_data),
        .pc             (pc),
        .inst           (inst),
        .inst_valid     (inst_valid)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: each new delivery must match the oldest acked, non-killed fetch.
    logic valid_prev = 1'b0;
    always @(negedge clock) begin
        if (inst_valid && !valid_prev) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_delivery: got pc 0x%0h inst 0x%0h with nothing pending", pc, inst);
            end else begin
                sb_item_t e;
                e = sb.pop_front();
                check("deliver_pc", pc, e.pc);
                check("deliver_inst", {32'h0, inst}, {32'h0, e.inst});
            end
        end
        valid_prev = inst_valid;
    end

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("req_seen", {63'h0, imem_req}, 64'h1);
    endtask

    // Serves one fetch: checks the address, waits, acks, and expects delivery one cycle later.
    task automatic serve_fetch(input logic [63:0] exp_addr, input int unsigned wait_cycles,
                               input logic [31:0] data);
        sb_item_t e;
        wait_req();
        check("fetch_addr", imem_addr, exp_addr);
        repeat (wait_cycles) @(negedge clock);
        check("addr_stable", imem_addr, exp_addr);
        imem_ack     = 1'b1;
        imem_rd_data = data;
        e.pc   = exp_addr;
        e.inst = data;
        sb.push_back(e);
        @(negedge clock);
        imem_ack     = 1'b0;
        imem_rd_data = '0;
        check("deliver_latency", {63'h0, inst_valid}, 64'h1);
        check("deliver_no_req", {63'h0, imem_req}, 64'h0);
    endtask

    initial begin
        vecs[0] = '{wait_cycles: 2, data: 32'hDEAD_BEEF, exp_addr: 64'h1000};
        vecs[1] = '{wait_cycles: 0, data: 32'h1111_1111, exp_addr: 64'h1004};
        vecs[2] = '{wait_cycles: 1, data: 32'h2222_2222, exp_addr: 64'h1008};
        vecs[3] = '{wait_cycles: 3, data: 32'h3333_3333, exp_addr: 64'h100C};

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_req", {63'h0, imem_req}, 64'h0);
        check("rst_valid", {63'h0, inst_valid}, 64'h0);
        check("rst_inst", {32'h0, inst}, {32'h0, NOP});
        check("rst_pc", pc, RADDR);
        reset = 1'b0;

        // Sequential fetches
        for (int i = 0; i < 4; i++) begin
            serve_fetch(vecs[i].exp_addr, vecs[i].wait_cycles, vecs[i].data);
        end

        // Branch redirect while delivering
        serve_fetch(64'h1010, 0, 32'hAAAA_0001);
        redirect_valid = 1'b1;
        pc_src         = PcOrReadDataPlusImm;
        branch_target  = 64'h2003;
        @(negedge clock);
        redirect_valid = 1'b0;
        pc_src         = PcPlus4;
        check("br_valid_drop", {63'h0, inst_valid}, 64'h0);
        check("br_addr", imem_addr, 64'h2000);

        // Redirect during an outstanding fetch: the late data is discarded
        mepc           = 64'h3000;
        redirect_valid = 1'b1;
        pc_src         = Mepc;
        @(negedge clock);
        redirect_valid = 1'b0;
        pc_src         = PcPlus4;
        check("kill_addr_hold", imem_addr, 64'h2000);
        check("kill_req_hold", {63'h0, imem_req}, 64'h1);
        @(negedge clock);
        imem_ack     = 1'b1;
        imem_rd_data = 32'h1234_5678;
        @(negedge clock);
        imem_ack     = 1'b0;
        imem_rd_data = '0;
        check("kill_no_valid", {63'h0, inst_valid}, 64'h0);
        check("kill_new_addr", imem_addr, 64'h3000);
        @(negedge clock);
        check("kill_no_valid2", {63'h0, inst_valid}, 64'h0);

        // Stall holds the delivered instruction
        serve_fetch(64'h3000, 0, 32'hCAFE_F00D);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("stall_pc", pc, 64'h3000);
            check("stall_inst", {32'h0, inst}, 64'hCAFE_F00D);
            check("stall_valid", {63'h0, inst_valid}, 64'h1);
            check("stall_req", {63'h0, imem_req}, 64'h0);
        end
        stall = 1'b0;
        @(negedge clock);
        check("unstall_addr", imem_addr, 64'h3004);
        check("unstall_req", {63'h0, imem_req}, 64'h1);

        // Trap beats a simultaneous Sepc redirect, acked in the same cycle
        trap           = 1'b1;
        trap_addr      = 64'h80;
        redirect_valid = 1'b1;
        pc_src         = Sepc;
        sepc           = 64'h4000;
        imem_ack       = 1'b1;
        imem_rd_data   = 32'h5555_5555;
        @(negedge clock);
        trap           = 1'b0;
        redirect_valid = 1'b0;
        pc_src         = PcPlus4;
        imem_ack       = 1'b0;
        imem_rd_data   = '0;
        check("trap_addr", imem_addr, 64'h80);
        check("trap_no_valid", {63'h0, inst_valid}, 64'h0);

        // Misaligned target is aligned; then pc+4 wraps to zero
        redirect_valid = 1'b1;
        pc_src         = PcOrReadDataPlusImm;
        branch_target  = 64'hFFFF_FFFF_FFFF_FFFE;
        imem_ack       = 1'b1;
        imem_rd_data   = 32'h6666_6666;
        @(negedge clock);
        redirect_valid = 1'b0;
        pc_src         = PcPlus4;
        imem_ack       = 1'b0;
        imem_rd_data   = '0;
        check("align_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        serve_fetch(64'hFFFF_FFFF_FFFF_FFFC, 0, 32'h7777_7777);
        serve_fetch(64'h0, 1, 32'h8888_8888);

        // Reset in the middle of a fetch
        @(negedge clock);
        check("pre_rst_req", {63'h0, imem_req}, 64'h1);
        check("pre_rst_addr", imem_addr, 64'h4);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_req", {63'h0, imem_req}, 64'h0);
        check("mid_rst_valid", {63'h0, inst_valid}, 64'h0);
        check("mid_rst_pc", pc, RADDR);
        @(negedge clock);
        reset        = 1'b0;
        imem_ack     = 1'b1;
        imem_rd_data = 32'h9999_9999;
        @(negedge clock);
        imem_ack     = 1'b0;
        imem_rd_data = '0;
        check("post_rst_addr", imem_addr, 64'h1000);
        check("post_rst_req", {63'h0, imem_req}, 64'h1);
        check("post_rst_valid", {63'h0, inst_valid}, 64'h0);
        serve_fetch(64'h1000, 1, 32'hABCD_0123);

        repeat (3) @(negedge clock);
        check("sb_drained", 64'(sb.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
